ext_irq_ctrl: RTL and testbench
===============================

EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of external interrupt sources (1..15).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have src_i  in  NUM_SRC  asynchronous interrupt request lines, one per source.
REQ-004 SHALL have irq_o  out  1  machine external interrupt request to core (feeds core irq input, mcause 0x8000000B).
REQ-005 SHALL have irq_ack_i  in  1  one-cycle pulse from core when the interrupt trap is taken.
REQ-006 SHALL have bus_valid  in  1, bus_we  in  1, bus_addr  in  4 (byte offset), bus_wdata  in  32, bus_rdata  out  32: single-cycle register access.

Function
REQ-007 SHALL pass each src_i bit through a 2-flop synchronizer before any use.
REQ-008 SHALL keep a PENDING register (NUM_SRC bits) and an ENABLE register (NUM_SRC bits).
REQ-009 SHALL map source i to ID i+1; ID 0 means "none".
REQ-010 SHALL select the winner as the lowest-index bit of PENDING & ENABLE.
REQ-011 SHALL decode registers: 0x0 PENDING (RO), 0x4 ENABLE (RW), 0x8 CLAIM (RO, side effect), 0xC COMPLETE (WO); other offsets read 0, writes ignored.
REQ-012 SHALL return bus_rdata combinationally in the same cycle as bus_valid, zero-extended; side effects take effect at the next clk edge.
REQ-013 SHALL run an FSM IDLE -> ASSERT -> WAIT_CLAIM -> IN_SERVICE -> IDLE.
REQ-014 IDLE: irq_o=0; go ASSERT when PENDING & ENABLE is nonzero.
REQ-015 ASSERT: irq_o=1; go WAIT_CLAIM on irq_ack_i; go IDLE if PENDING & ENABLE becomes zero (e.g. ENABLE write) before ack.
REQ-016 WAIT_CLAIM: irq_o=0; CLAIM read returns winner ID, clears that PENDING bit, stores ID in an in-service register, go IN_SERVICE; if no winner, returns 0 and go IDLE.
REQ-017 IN_SERVICE: irq_o=0; COMPLETE write with bus_wdata[3:0] equal to in-service ID goes IDLE; mismatched ID ignored.
REQ-018 CLAIM read in IDLE or ASSERT SHALL return winner ID without side effect; in IN_SERVICE SHALL return 0.
REQ-019 When a new source event and a CLAIM clear hit the same PENDING bit in one cycle, the set SHALL win.
REQ-020 irq_ack_i outside ASSERT SHALL be ignored.
REQ-021 irq_o SHALL be a registered output (decoded from state register), no combinational path from src_i or bus.

Reset
REQ-022 On rst_n low: state IDLE, irq_o=0, PENDING=0, ENABLE=0, in-service ID=0, synchronizers=0.
REQ-023 Reset asserted mid-service SHALL abandon the in-service ID; no completion required afterward.

Configuration
REQ-024 Macro EXT_IRQ_EDGE_EN: when defined, a PENDING bit SHALL set on a synchronized 0->1 transition only (edge detect flop per source).
REQ-025 Without EXT_IRQ_EDGE_EN, a PENDING bit SHALL set every cycle its synchronized source is high (level mode; claim clear re-sets next cycle if still high).

Structure
REQ-026 Package ext_irq_pkg SHALL hold NUM_SRC default, ID width (4), register offset constants, and the FSM state enum.
REQ-027 Priority selection SHALL be a sub-module irq_prio_enc (PENDING & ENABLE in, valid + ID out, combinational).

Verification
REQ-028 ENABLE=0x04, pulse src_i[2] -> irq_o=1 after sync+1 cycles; ack -> irq_o=0; CLAIM reads 3, PENDING=0; COMPLETE 3 -> IDLE.
REQ-029 ENABLE=0xFF, src_i[5] and src_i[1] together -> CLAIM returns 2; after COMPLETE 2, irq_o reasserts, next CLAIM returns 6.
REQ-030 In ASSERT, write ENABLE=0 -> irq_o drops next cycle, state IDLE, PENDING retained.
REQ-031 IN_SERVICE ID 3, write COMPLETE 4 -> stays IN_SERVICE, irq_o=0; COMPLETE 3 -> IDLE.
REQ-032 EXT_IRQ_EDGE_EN defined, src_i[0] held high across claim -> no re-pend; undefined -> PENDING[0] re-sets next cycle.
REQ-033 Assert rst_n low in IN_SERVICE -> all registers zero, irq_o=0; after release, normal first-interrupt flow works.

Source files
------------

// File: rtl/ext_irq_pkg.sv
// -----------------------------------------------------------------------------
// ext_irq_pkg
// Shared definitions for the external interrupt controller slice:
//   - NUM_SRC_DEF : default number of external interrupt sources
//   - IRQ_ID_W    : width of a source ID (ID 0 = "none", source i = ID i+1)
//   - OFF_*       : register byte offsets on the 4-bit bus address
//   - irq_state_e : controller FSM state encoding
//   - id_to_word  : zero-extends an ID onto the 32-bit read bus
// -----------------------------------------------------------------------------
package ext_irq_pkg;

    localparam int NUM_SRC_DEF = 8;
    localparam int IRQ_ID_W    = 4;

    localparam logic [3:0] OFF_PENDING  = 4'h0;
    localparam logic [3:0] OFF_ENABLE   = 4'h4;
    localparam logic [3:0] OFF_CLAIM    = 4'h8;
    localparam logic [3:0] OFF_COMPLETE = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ASSERT     = 2'd1,
        ST_WAIT_CLAIM = 2'd2,
        ST_IN_SERVICE = 2'd3
    } irq_state_e;

    // Places an interrupt ID in the low bits of a read-data word.
    function automatic logic [31:0] id_to_word(input logic [IRQ_ID_W-1:0] id);
        return {{(32 - IRQ_ID_W){1'b0}}, id};
    endfunction

endpackage : ext_irq_pkg

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder: the lowest-index asserted request wins.
// Ports:
//   i_req   in  NUM_SRC  requests (PENDING & ENABLE)
//   o_valid out  1       at least one request asserted
//   o_id    out  ID_W    winner ID (index + 1), 0 when no request
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        o_valid = 1'b0;
        o_id    = {ID_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i + 1);
            end else begin
                o_valid = o_valid;
                o_id    = o_id;
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/ext_irq_ctrl.sv
// -----------------------------------------------------------------------------
// ext_irq_ctrl
// Machine external interrupt controller. Synchronizes NUM_SRC asynchronous
// request lines, latches them into PENDING, masks with ENABLE, and signals the
// core through a registered irq_o. The core acknowledges the trap, claims the
// winning ID over the register bus and finally writes it back to COMPLETE.
//
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        asynchronous active-low reset
//   src_i      in   NUM_SRC  asynchronous interrupt request lines
//   irq_o      out  1        external interrupt request to the core
//   irq_ack_i  in   1        one-cycle pulse when the core takes the trap
//   bus_valid  in   1        register access strobe
//   bus_we     in   1        1 = write, 0 = read
//   bus_addr   in   4        byte offset (0x0 PENDING, 0x4 ENABLE,
//                            0x8 CLAIM, 0xC COMPLETE)
//   bus_wdata  in   32       write data
//   bus_rdata  out  32       read data, combinational in the access cycle
//
// Build option: define EXT_IRQ_EDGE_EN to latch PENDING only on a
// synchronized 0->1 transition; otherwise PENDING re-sets every cycle the
// synchronized source is high (level mode).
// -----------------------------------------------------------------------------
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_o,
    input  logic               irq_ack_i,
    input  logic               bus_valid,
    input  logic               bus_we,
    input  logic [3:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata
);

    logic [NUM_SRC-1:0]  r_sync1;
    logic [NUM_SRC-1:0]  r_sync2;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_enable;
    logic [IRQ_ID_W-1:0] r_in_service;
    irq_state_e          r_state;
    logic                r_irq;

    logic [NUM_SRC-1:0]  w_set;
    logic [NUM_SRC-1:0]  w_clr;
    logic [NUM_SRC-1:0]  w_pend_en;
    logic                w_valid;
    logic [IRQ_ID_W-1:0] w_id;
    logic                w_rd;
    logic                w_wr;
    logic                w_claim_rd;
    logic                w_claim_take;
    logic                w_enable_wr;
    logic                w_complete_ok;
    logic                w_unused;

    assign w_pend_en = r_pending & r_enable;
    assign w_rd      = bus_valid & ~bus_we;
    assign w_wr      = bus_valid &  bus_we;

    // Only a CLAIM read while waiting for the claim changes state/PENDING.
    assign w_claim_rd    = w_rd & (bus_addr == OFF_CLAIM) & (r_state == ST_WAIT_CLAIM);
    assign w_claim_take  = w_claim_rd & w_valid;
    assign w_enable_wr   = w_wr & (bus_addr == OFF_ENABLE);
    assign w_complete_ok = w_wr & (bus_addr == OFF_COMPLETE) & (r_state == ST_IN_SERVICE)
                         & (bus_wdata[IRQ_ID_W-1:0] == r_in_service);

    // Write-data bits beyond ENABLE/COMPLETE fields are intentionally ignored.
    assign w_unused = ^bus_wdata;

    assign irq_o = r_irq;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (IRQ_ID_W)
    ) u_prio_enc (
        .i_req   (w_pend_en),
        .o_valid (w_valid),
        .o_id    (w_id)
    );

    // Two-flop synchronizer for the asynchronous request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= {NUM_SRC{1'b0}};
            r_sync2 <= {NUM_SRC{1'b0}};
        end else begin
            r_sync1 <= src_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef EXT_IRQ_EDGE_EN
    logic [NUM_SRC-1:0] r_sync_d;

    // Delayed copy of the synchronized sources for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d <= {NUM_SRC{1'b0}};
        end else begin
            r_sync_d <= r_sync2;
        end
    end

    assign w_set = r_sync2 & ~r_sync_d;
`else
    // Level mode: a high source keeps re-setting its PENDING bit.
    assign w_set = r_sync2;
`endif

    // One-hot clear mask for the bit being claimed this cycle.
    always_comb begin
        w_clr = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_claim_take && (w_id == IRQ_ID_W'(i + 1))) begin
                w_clr[i] = 1'b1;
            end else begin
                w_clr[i] = 1'b0;
            end
        end
    end

    // PENDING: clear on claim first, then OR in new events so a set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= {NUM_SRC{1'b0}};
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // ENABLE register, written through offset 0x4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= {NUM_SRC{1'b0}};
        end else if (w_enable_wr) begin
            r_enable <= bus_wdata[NUM_SRC-1:0];
        end else begin
            r_enable <= r_enable;
        end
    end

    // Controller FSM; irq_o is registered alongside the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_irq        <= 1'b0;
            r_in_service <= {IRQ_ID_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_service <= {IRQ_ID_W{1'b0}};
                    if (w_valid) begin
                        r_state <= ST_ASSERT;
                        r_irq   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    r_in_service <= r_in_service;
                    if (irq_ack_i) begin
                        r_state <= ST_WAIT_CLAIM;
                        r_irq   <= 1'b0;
                    end else if (!w_valid) begin
                        // Request withdrawn (e.g. ENABLE cleared) before the ack.
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end else begin
                        r_state <= ST_ASSERT;
                        r_irq   <= 1'b1;
                    end
                end
                ST_WAIT_CLAIM: begin
                    r_irq <= 1'b0;
                    if (w_claim_take) begin
                        r_state      <= ST_IN_SERVICE;
                        r_in_service <= w_id;
                    end else if (w_claim_rd) begin
                        // Claim found nothing to serve: spurious, drop back.
                        r_state      <= ST_IDLE;
                        r_in_service <= {IRQ_ID_W{1'b0}};
                    end else begin
                        r_state      <= ST_WAIT_CLAIM;
                        r_in_service <= r_in_service;
                    end
                end
                ST_IN_SERVICE: begin
                    r_irq <= 1'b0;
                    if (w_complete_ok) begin
                        r_state      <= ST_IDLE;
                        r_in_service <= {IRQ_ID_W{1'b0}};
                    end else begin
                        r_state      <= ST_IN_SERVICE;
                        r_in_service <= r_in_service;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_irq        <= 1'b0;
                    r_in_service <= {IRQ_ID_W{1'b0}};
                end
            endcase
        end
    end

    // Combinational read mux; unmapped offsets and writes return zero.
    always_comb begin
        bus_rdata = 32'h0000_0000;
        if (w_rd) begin
            case (bus_addr)
                OFF_PENDING: bus_rdata = {{(32 - NUM_SRC){1'b0}}, r_pending};
                OFF_ENABLE:  bus_rdata = {{(32 - NUM_SRC){1'b0}}, r_enable};
                OFF_CLAIM: begin
                    if (r_state == ST_IN_SERVICE) begin
                        bus_rdata = 32'h0000_0000;
                    end else begin
                        bus_rdata = id_to_word(w_id);
                    end
                end
                default:     bus_rdata = 32'h0000_0000;
            endcase
        end else begin
            bus_rdata = 32'h0000_0000;
        end
    end

endmodule : ext_irq_ctrl

// File: tb/tb_ext_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ext_irq_ctrl
// Directed self-checking bench for ext_irq_ctrl (NUM_SRC = 8). Inputs are
// driven on the falling edge; outputs are sampled between edges.
// -----------------------------------------------------------------------------
module tb_ext_irq_ctrl;

    localparam int NSRC = 8;

    logic            clk;
    logic            rst_n;
    logic [NSRC-1:0] src_i;
    logic            irq_o;
    logic            irq_ack_i;
    logic            bus_valid;
    logic            bus_we;
    logic [3:0]      bus_addr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;

    int checks;
    int failures;

    ext_irq_ctrl #(.NUM_SRC(NSRC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_i     (src_i),
        .irq_o     (irq_o),
        .irq_ack_i (irq_ack_i),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = addr;
        #1;
        check(tag, bus_rdata, exp);
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = 32'h0;
    endtask

    task automatic pulse_src(input logic [NSRC-1:0] m);
        @(negedge clk);
        src_i = m;
        @(negedge clk);
        src_i = '0;
    endtask

    task automatic wait_irq(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (irq_o !== 1'b1 && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'b0, irq_o}, 32'h1);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        irq_ack_i = 1'b1;
        @(posedge clk);
        #1;
        irq_ack_i = 1'b0;
        check(tag, {31'b0, irq_o}, 32'h0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        src_i     = '0;
        irq_ack_i = 1'b0;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and decode of unmapped / write-only offsets
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        rd_chk(4'h0, 32'h0, "rst_pending");
        rd_chk(4'h4, 32'h0, "rst_enable");
        rd_chk(4'h8, 32'h0, "rst_claim");
        wr(4'h1, 32'hFF);
        rd_chk(4'h4, 32'h0, "bad_wr_ignored");
        rd_chk(4'hC, 32'h0, "complete_reads0");

        // Basic flow: single source 2, exact sync latency
        wr(4'h4, 32'h04);
        rd_chk(4'h4, 32'h04, "enable_rb");
        pulse_src(8'h04);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_not_yet", {31'b0, irq_o}, 32'h0);
        @(posedge clk);
        #1;
        check("irq_latency", {31'b0, irq_o}, 32'h1);
        ack("ack_drop_1");
        rd_chk(4'h8, 32'h3, "claim_3");
        rd_chk(4'h0, 32'h0, "pend_clr_3");
        rd_chk(4'h8, 32'h0, "claim_in_service_0");
        wr(4'hC, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        check("idle_quiet", {31'b0, irq_o}, 32'h0);

        // Two simultaneous sources: lowest index first
        wr(4'h4, 32'hFF);
        pulse_src(8'h22);
        wait_irq(8, "irq_two_src");
        ack("ack_drop_2");
        rd_chk(4'h8, 32'h2, "claim_2");
        rd_chk(4'h0, 32'h20, "pend_left_5");
        wr(4'hC, 32'h2);
        wait_irq(4, "irq_reassert");
        ack("ack_drop_3");
        rd_chk(4'h8, 32'h6, "claim_6");
        rd_chk(4'h0, 32'h0, "pend_empty");
        wr(4'hC, 32'h6);

        // Withdraw by ENABLE in ASSERT; claim peek without side effect
        pulse_src(8'h08);
        wait_irq(8, "irq_src3");
        rd_chk(4'h8, 32'h4, "claim_peek_assert");
        rd_chk(4'h0, 32'h08, "pend_after_peek");
        check("irq_held", {31'b0, irq_o}, 32'h1);
        wr(4'h4, 32'h00);
        @(posedge clk);
        #1;
        check("irq_withdrawn", {31'b0, irq_o}, 32'h0);
        rd_chk(4'h0, 32'h08, "pend_retained");
        // Ack while idle must be ignored
        @(negedge clk);
        irq_ack_i = 1'b1;
        @(negedge clk);
        irq_ack_i = 1'b0;
        wr(4'h4, 32'hFF);
        wait_irq(4, "irq_after_reenable");
        ack("ack_drop_4");
        rd_chk(4'h8, 32'h4, "claim_4");
        wr(4'hC, 32'h4);

        // Mismatched COMPLETE keeps IN_SERVICE
        pulse_src(8'h04);
        wait_irq(8, "irq_ms");
        ack("ack_drop_5");
        rd_chk(4'h8, 32'h3, "claim_3b");
        pulse_src(8'h01);
        repeat (3) @(posedge clk);
        rd_chk(4'h0, 32'h01, "pend_during_service");
        wr(4'hC, 32'h4);
        #1;
        check("irq_bad_complete", {31'b0, irq_o}, 32'h0);
        rd_chk(4'h8, 32'h0, "still_in_service");
        wr(4'hC, 32'h3);
        wait_irq(4, "irq_after_good_complete");
        ack("ack_drop_6");
        rd_chk(4'h8, 32'h1, "claim_1");
        wr(4'hC, 32'h1);

        // Source held high across claim: level re-pends, edge does not
        @(negedge clk);
        src_i = 8'h01;
        wait_irq(8, "irq_held_src");
        ack("ack_drop_7");
        rd_chk(4'h8, 32'h1, "claim_held");
`ifdef EXT_IRQ_EDGE_EN
        rd_chk(4'h0, 32'h0, "edge_no_repend");
        wr(4'hC, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("edge_no_irq", {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        src_i = '0;
`else
        rd_chk(4'h0, 32'h01, "level_repend");
        wr(4'hC, 32'h1);
        wait_irq(4, "level_reirq");
        @(negedge clk);
        src_i = '0;
        repeat (3) @(posedge clk);
        ack("ack_drop_8");
        rd_chk(4'h8, 32'h1, "claim_level");
        rd_chk(4'h0, 32'h0, "pend_level_clr");
        wr(4'hC, 32'h1);
`endif

        // Reset in IN_SERVICE abandons everything
        pulse_src(8'h04);
        wait_irq(8, "irq_pre_rst");
        ack("ack_drop_9");
        rd_chk(4'h8, 32'h3, "claim_pre_rst");
        pulse_src(8'h01);
        repeat (3) @(posedge clk);
        rd_chk(4'h0, 32'h01, "pend_pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_irq", {31'b0, irq_o}, 32'h0);
        rd_chk(4'h0, 32'h0, "rst_mid_pending");
        rd_chk(4'h4, 32'h0, "rst_mid_enable");
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk(4'h8, 32'h0, "post_rst_claim");
        wr(4'h4, 32'h04);
        pulse_src(8'h04);
        wait_irq(8, "post_rst_irq");
        ack("ack_drop_10");
        rd_chk(4'h8, 32'h3, "post_rst_claim_3");
        wr(4'hC, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {31'b0, irq_o}, 32'h0);
        rd_chk(4'h0, 32'h0, "post_rst_pend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ext_irq_ctrl
